// File: rtl/pe_mac_window.sv
`default_nettype none
// ============================================================================
//  Module      : pe_mac_window
//  Description : MAC processing element. Accumulates a runtime-sized window
//                of feature*weight products and emits one result per window,
//                with optional ReLU and saturation/truncation.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_mac_window #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int OUT_W    = 16,
    parameter int MAX_LEN  = 32,
    parameter int SIGNED   = 1,
    parameter int SAT      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           relu_en,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              input_feature,
    input  logic [WEIGHT_W-1:0]            weight,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_W-1:0]               output_feature
);

    localparam int c_prod_w = DATA_W + WEIGHT_W;
    localparam int c_acc_w  = DATA_W + WEIGHT_W + $clog2(MAX_LEN);
    localparam int c_len_w  = $clog2(MAX_LEN + 1);
    localparam int c_ext_w  = (c_acc_w > OUT_W) ? c_acc_w : OUT_W + 1;

    localparam logic [c_len_w-1:0] c_max_len = c_len_w'(MAX_LEN);
    localparam logic [c_len_w-1:0] c_len_one = c_len_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_acc_w-1:0]   r_acc;
    logic [c_len_w-1:0]   r_cnt;
    logic [c_len_w-1:0]   r_len;
    logic                 r_relu;
    logic [OUT_W-1:0]     r_out_feature;

    logic                 w_accept;
    logic                 w_start;
    logic                 w_load_out;
    logic [c_len_w-1:0]   w_len_in;
    logic [c_len_w-1:0]   w_cnt_inc;
    logic [c_prod_w-1:0]  w_op_a;
    logic [c_prod_w-1:0]  w_op_b;
    logic [c_prod_w-1:0]  w_prod;
    logic [c_acc_w-1:0]   w_prod_ext;
    logic [c_acc_w-1:0]   w_acc_next;
    logic                 w_relu_eff;
    logic [c_ext_w-1:0]   w_ext;
    logic                 w_sign;
    logic                 w_s_ovf;
    logic                 w_u_ovf;
    logic [OUT_W-1:0]     w_result;

    assign out_valid      = (r_state == S_OUT);
    assign in_ready       = ~out_valid | out_ready;
    assign w_accept       = in_valid & in_ready;
    assign output_feature = r_out_feature;
    assign w_cnt_inc      = r_cnt + c_len_one;

    // A new window opens on any accept outside ACC: from IDLE or as the
    // back-to-back follower of a handed-off result.
    assign w_start = w_accept & (r_state != S_ACC) & ~clr;

    always_comb begin
        w_len_in = cfg_len;
        if (cfg_len == '0) begin
            w_len_in = c_len_one;
        end else if (cfg_len > c_max_len) begin
            w_len_in = c_max_len;
        end
    end

    // Operands widened to the product width; low product bits are then
    // correct for either operand interpretation.
    always_comb begin
        if (SIGNED != 0) begin
            w_op_a = c_prod_w'($signed(input_feature));
            w_op_b = c_prod_w'($signed(weight));
        end else begin
            w_op_a = c_prod_w'(input_feature);
            w_op_b = c_prod_w'(weight);
        end
        w_prod = w_op_a * w_op_b;
        if (SIGNED != 0) begin
            w_prod_ext = c_acc_w'($signed(w_prod));
        end else begin
            w_prod_ext = c_acc_w'(w_prod);
        end
    end

    assign w_acc_next = (r_state == S_ACC) ? (r_acc + w_prod_ext) : w_prod_ext;
    assign w_relu_eff = (r_state == S_ACC) ? r_relu : relu_en;

    // Result formatting: ReLU, then clamp or truncate to OUT_W.
    always_comb begin
        if (SIGNED != 0) begin
            w_ext = c_ext_w'($signed(w_acc_next));
        end else begin
            w_ext = c_ext_w'(w_acc_next);
        end
        w_sign   = w_ext[c_ext_w-1];
        w_s_ovf  = ~((&w_ext[c_ext_w-1:OUT_W-1]) | ~(|w_ext[c_ext_w-1:OUT_W-1]));
        w_u_ovf  = |w_ext[c_ext_w-1:OUT_W];
        w_result = w_ext[OUT_W-1:0];
        if ((SIGNED != 0) && w_relu_eff && w_sign) begin
            w_result = '0;
        end else if ((SAT != 0) && (SIGNED != 0) && w_s_ovf) begin
            w_result = {w_sign, {(OUT_W-1){~w_sign}}};
        end else if ((SAT != 0) && (SIGNED == 0) && w_u_ovf) begin
            w_result = '1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_out   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_len_in == c_len_one) begin
                        w_next_state = S_OUT;
                        w_load_out   = 1'b1;
                    end else begin
                        w_next_state = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (w_accept && (w_cnt_inc == r_len)) begin
                    w_next_state = S_OUT;
                    w_load_out   = 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (w_accept) begin
                        if (w_len_in == c_len_one) begin
                            w_next_state = S_OUT;
                            w_load_out   = 1'b1;
                        end else begin
                            w_next_state = S_ACC;
                        end
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (clr) begin
            w_next_state = S_IDLE;
            w_load_out   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_len         <= c_len_one;
            r_relu        <= 1'b0;
            r_out_feature <= '0;
        end else begin
            if (clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_start) begin
                r_acc  <= w_prod_ext;
                r_cnt  <= c_len_one;
                r_len  <= w_len_in;
                r_relu <= relu_en;
            end else if (w_accept && (r_state == S_ACC)) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_inc;
            end
            if (w_load_out) begin
                r_out_feature <= w_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_window.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_mac_window
//  Description : Directed scoreboard bench; a signed/saturating and an
//                unsigned/truncating PE share one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_mac_window;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [5:0]  cfg_len = 6'd1;
    logic        relu_en = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  input_feature = 8'd0;
    logic [7:0]  weight = 8'd0;
    logic        out_ready = 1'b1;

    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out;
    logic        u_in_ready, u_out_valid;
    logic [15:0] u_out;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] q_s[$];
    logic [15:0] q_u[$];
    longint      m_acc_s;
    longint      m_acc_u;
    bit          m_relu;

    always #5 clk = ~clk;

    pe_mac_window #(.DATA_W(8), .WEIGHT_W(8), .OUT_W(16), .MAX_LEN(32), .SIGNED(1), .SAT(1)) u_s (
        .clk(clk), .rst(rst), .clr(clr), .cfg_len(cfg_len), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(s_in_ready), .input_feature(input_feature), .weight(weight),
        .out_valid(s_out_valid), .out_ready(out_ready), .output_feature(s_out)
    );

    pe_mac_window #(.DATA_W(8), .WEIGHT_W(8), .OUT_W(16), .MAX_LEN(32), .SIGNED(0), .SAT(0)) u_u (
        .clk(clk), .rst(rst), .clr(clr), .cfg_len(cfg_len), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(u_in_ready), .input_feature(input_feature), .weight(weight),
        .out_valid(u_out_valid), .out_ready(out_ready), .output_feature(u_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fmt_s(input longint acc, input bit relu);
        if (relu && acc < 0) return 16'h0000;
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return acc[15:0];
    endfunction

    task automatic start_win(input logic [5:0] len, input bit relu);
        cfg_len = len;
        relu_en = relu;
        m_relu  = relu;
        m_acc_s = 0;
        m_acc_u = 0;
    endtask

    task automatic end_win();
        q_s.push_back(fmt_s(m_acc_s, m_relu));
        q_u.push_back(m_acc_u[15:0]);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        bit done = 0;
        in_valid      = 1'b1;
        input_feature = a;
        weight        = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (s_in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
        m_acc_s += longint'($signed(a)) * longint'($signed(b));
        m_acc_u += longint'(a) * longint'(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rst && s_out_valid && out_ready) begin
                    if (q_s.size() == 0) check("s_unexpected_out", {16'd0, s_out}, 32'hFFFF_FFFF);
                    else check("s_result", {16'd0, s_out}, {16'd0, q_s.pop_front()});
                end
                if (rst && u_out_valid && out_ready) begin
                    if (q_u.size() == 0) check("u_unexpected_out", {16'd0, u_out}, 32'hFFFF_FFFF);
                    else check("u_result", {16'd0, u_out}, {16'd0, q_u.pop_front()});
                end
            end
        join_none

        // Reset state
        #12;
        check("rst_out_valid", {31'd0, s_out_valid}, 32'd0);
        check("rst_out", {16'd0, s_out}, 32'd0);
        check("rst_in_ready", {31'd0, s_in_ready}, 32'd1);
        check("rst_u_out", {16'd0, u_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Test 1: len 3, back-to-back, latency; mid-window cfg_len change ignored
        start_win(6'd3, 1'b0);
        send(8'd1, 8'd2);
        cfg_len = 6'd1;
        send(8'd3, 8'd4);
        check("t1_no_early_valid", {31'd0, s_out_valid}, 32'd0);
        send(8'd5, 8'd6);
        end_win();
        @(negedge clk);
        check("t1_latency_valid", {31'd0, s_out_valid}, 32'd1);
        check("t1_value", {16'd0, u_out}, 32'h002C);
        idle(2);

        // Test 2: signed negative, then with ReLU
        start_win(6'd2, 1'b0);
        send(8'hFF, 8'd3);
        send(8'hFF, 8'd3);
        end_win();
        idle(2);
        start_win(6'd2, 1'b1);
        send(8'hFF, 8'd3);
        send(8'hFF, 8'd3);
        end_win();
        idle(2);

        // Test 3: len 27 positive and negative extremes
        start_win(6'd27, 1'b0);
        for (int i = 0; i < 27; i++) send(8'd127, 8'd127);
        end_win();
        idle(2);
        start_win(6'd27, 1'b0);
        for (int i = 0; i < 27; i++) send(8'h80, 8'd127);
        end_win();
        idle(2);

        // Test 4: backpressure then same-cycle handoff
        out_ready = 1'b0;
        start_win(6'd2, 1'b0);
        send(8'd2, 8'd3);
        send(8'd4, 8'd5);
        end_win();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_in_ready_low", {31'd0, s_in_ready}, 32'd0);
            check("t4_valid_held", {31'd0, s_out_valid}, 32'd1);
            check("t4_out_stable", {16'd0, s_out}, 32'h001A);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        start_win(6'd1, 1'b0);
        send(8'd3, 8'd3);
        end_win();
        check("t4_new_window_valid", {31'd0, s_out_valid}, 32'd1);
        idle(2);

        // Test 5: async reset mid-window
        start_win(6'd3, 1'b0);
        send(8'd9, 8'd9);
        send(8'd9, 8'd9);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, s_out_valid}, 32'd0);
        check("t5_rst_ready", {31'd0, s_in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        start_win(6'd3, 1'b0);
        for (int i = 0; i < 3; i++) send(8'd1, 8'd1);
        end_win();
        idle(2);

        // Test 6: soft clear drops window and its pair; len 0 and over-max clamps
        start_win(6'd3, 1'b0);
        send(8'd9, 8'd9);
        send(8'd9, 8'd9);
        clr           = 1'b1;
        in_valid      = 1'b1;
        input_feature = 8'd50;
        weight        = 8'd50;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        check("t6_clr_valid", {31'd0, s_out_valid}, 32'd0);
        start_win(6'd3, 1'b0);
        for (int i = 0; i < 3; i++) send(8'd2, 8'd2);
        end_win();
        idle(2);
        start_win(6'd0, 1'b0);
        send(8'd7, 8'd1);
        end_win();
        idle(2);
        start_win(6'd63, 1'b0);
        for (int i = 0; i < 32; i++) send(8'd1, 8'd1);
        end_win();
        idle(4);

        check("s_queue_drained", q_s.size(), 32'd0);
        check("u_queue_drained", q_u.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
